alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters, e.g. the integer pipe and a debug/CSR unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, drives the ALU operand/control inputs from registers, and returns a registered result plus a zero flag to the winner.
- One operation is in flight at a time. Fixed 2-cycle accept-to-response latency when there is no back-pressure.

---
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin front end for one shared combinational ALU
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_src_A,
    output logic [WIDTH-1:0] alu_src_B,
    output logic [OP_W-1:0]  alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic             resp_taken;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    // Arbitration and next-state: a lone requester always wins, contention alternates.
    always_comb begin
        grant      = 1'b0;
        accept     = 1'b0;
        resp_taken = 1'b0;
        state_nxt  = state;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        case (state)
            IDLE: begin
                accept = req0_valid | req1_valid;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_taken = owner ? resp1_ready : resp0_ready;
                if (resp_taken) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, ALU drive registers and the captured result for the current owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_src_A  <= '0;
            alu_src_B  <= '0;
            alu_ctrl   <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                alu_src_A  <= grant ? req1_a  : req0_a;
                alu_src_B  <= grant ? req1_b  : req0_b;
                alu_ctrl   <= grant ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                zero_q   <= (alu_result == '0);
            end
        end
    end

    // Ready is combinational from valid; responses are steered only to the owner.
    always_comb begin
        req0_ready   = (state == IDLE) && req0_valid && !grant;
        req1_ready   = (state == IDLE) && req1_valid && grant;
        resp0_valid  = (state == RESP) && !owner;
        resp1_valid  = (state == RESP) && owner;
        resp0_result = resp0_valid ? result_q : '0;
        resp1_result = resp1_valid ? result_q : '0;
        resp0_zero   = resp0_valid & zero_q;
        resp1_zero   = resp1_valid & zero_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        resp0_valid, resp0_ready, resp0_zero;
    logic        resp1_valid, resp1_ready, resp1_zero;
    logic [31:0] resp0_result, resp1_result;
    logic [31:0] alu_src_A, alu_src_B, alu_result;
    logic [3:0]  alu_ctrl;

    int compared   = 0;
    int mismatched = 0;
    int ncyc       = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          grant_log[$];

    int          acc_t0, acc_t1;
    bit          prev_v0 = 0, prev_v1 = 0;
    bit          pend = 0;
    logic [67:0] pend_drive;

    alu_share_arbiter #(.WIDTH(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: AND, OR, ADD, SUB, SLT; everything else returns 0.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_src_A & alu_src_B;
            4'b0001: alu_result = alu_src_A | alu_src_B;
            4'b0010: alu_result = alu_src_A + alu_src_B;
            4'b0110: alu_result = alu_src_A - alu_src_B;
            4'b0111: alu_result = ($signed(alu_src_A) < $signed(alu_src_B)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: drive-register check, latency, exclusivity, and scoreboard pops.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            pend    = 0;
            prev_v0 = 0;
            prev_v1 = 0;
        end else begin
            if (pend) begin
                chk("alu_drive", {alu_src_A, alu_src_B, alu_ctrl}, pend_drive);
                pend = 0;
            end
            if (req0_valid && req0_ready) begin
                chk("single_ready", req1_ready, 1'b0);
                grant_log.push_back(0);
                acc_t0     = ncyc;
                pend       = 1;
                pend_drive = {req0_a, req0_b, req0_op};
            end
            if (req1_valid && req1_ready) begin
                grant_log.push_back(1);
                acc_t1     = ncyc;
                pend       = 1;
                pend_drive = {req1_a, req1_b, req1_op};
            end
            if (resp0_valid) begin
                chk("resp_excl0", resp1_valid, 1'b0);
                if (!prev_v0) chk("latency0", ncyc - acc_t0, 2);
                chk("sb0_has_entry", q0.size() != 0, 1'b1);
                if (q0.size() != 0) begin
                    chk("resp0", {resp0_zero, resp0_result}, q0[0]);
                    if (resp0_ready) void'(q0.pop_front());
                end
            end
            if (resp1_valid) begin
                chk("resp_excl1", resp0_valid, 1'b0);
                if (!prev_v1) chk("latency1", ncyc - acc_t1, 2);
                chk("sb1_has_entry", q1.size() != 0, 1'b1);
                if (q1.size() != 0) begin
                    chk("resp1", {resp1_zero, resp1_result}, q1[0]);
                    if (resp1_ready) void'(q1.pop_front());
                end
            end
            prev_v0 = resp0_valid;
            prev_v1 = resp1_valid;
        end
    end

    task automatic issue(input int ch, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [32:0] exp);
        bit got = 0;
        if (ch == 0) begin
            q0.push_back(exp);
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            q1.push_back(exp);
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((ch == 0 && req0_ready) || (ch == 1 && req1_ready)) begin
                got = 1;
                break;
            end
        end
        chk("handshake", got, 1'b1);
        @(posedge clk); #1;
        if (ch == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !resp0_valid && !resp1_valid) begin
                done = 1;
                break;
            end
        end
        chk("drain", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic contend(input int target);
        int n0 = 0;
        int n1 = 0;
        bit ok = 0;
        bit d0, d1;
        grant_log.delete();
        q0.push_back({1'b0, 32'd2});
        q1.push_back({1'b0, 32'h0000_00FF});
        req0_a = 32'd1;    req0_b = 32'd1;    req0_op = 4'b0010; req0_valid = 1'b1;
        req1_a = 32'h0F;   req1_b = 32'hF0;   req1_op = 4'b0001; req1_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            d0 = 0;
            d1 = 0;
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                n0++;
                if (n0 < target) q0.push_back({1'b0, 32'd2});
                else             d0 = 1;
            end
            if (req1_valid && req1_ready) begin
                n1++;
                if (n1 < target) q1.push_back({1'b0, 32'h0000_00FF});
                else             d1 = 1;
            end
            @(posedge clk); #1;
            if (d0) req0_valid = 1'b0;
            if (d1) req1_valid = 1'b0;
            if (n0 >= target && n1 >= target) begin
                ok = 1;
                break;
            end
        end
        chk("contend_done", ok, 1'b1);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ready"},  {req0_ready, req1_ready}, 2'b00);
        chk({tag, "_rvalid"}, {resp0_valid, resp1_valid}, 2'b00);
        chk({tag, "_result"}, {resp0_result, resp1_result, resp0_zero, resp1_zero}, 66'd0);
        chk({tag, "_alu"},    {alu_src_A, alu_src_B, alu_ctrl}, 68'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        resp0_ready = 1; resp1_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD, SUB to zero, SLT
        issue(0, 32'd5, 32'd7, 4'b0010, {1'b0, 32'd12});
        wait_drain();
        issue(0, 32'd3, 32'd3, 4'b0110, {1'b1, 32'd0});
        wait_drain();
        issue(0, 32'd2, 32'd9, 4'b0111, {1'b0, 32'd1});
        wait_drain();

        // Continuous contention from reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        contend(2);
        wait_drain();
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("grant_order", grant_log[i], i % 2);
        end

        // Back-pressure on requester 1 while requester 0 waits
        resp1_ready = 1'b0;
        issue(1, 32'hFF, 32'h3C, 4'b0000, {1'b0, 32'h3C});
        q0.push_back({1'b0, 32'd12});
        req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'b0010; req0_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {resp1_valid, resp1_result, req0_ready}, {1'b1, 32'h3C, 1'b0});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        resp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {resp1_valid, req0_ready}, 2'b10);
        @(negedge clk);
        chk("bp_next", {resp1_valid, req0_ready}, 2'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_drain();

        // Undefined op passes through, ALU returns 0
        issue(0, 32'd7, 32'd7, 4'b1111, {1'b1, 32'd0});
        wait_drain();

        // Reset during EXEC
        issue(0, 32'd5, 32'd7, 4'b0010, {1'b0, 32'd12});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outs("rst_exec");
        end

        // Reset during RESP
        issue(1, 32'd5, 32'd7, 4'b0010, {1'b0, 32'd12});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outs("rst_resp");
        end

        // First contention after reset goes to requester 0
        @(posedge clk); #1;
        contend(1);
        wait_drain();
        chk("post_rst_first", (grant_log.size() != 0) ? grant_log[0] : -1, 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
